// File: rtl/emergency_preempt_ctrl_pkg.sv
// Shared types and timing defaults for the emergency preemption controller
// and the normal lane sequencer.
package emergency_preempt_ctrl_pkg;

  localparam int unsigned NUM_APPROACHES     = 4;
  localparam int unsigned LANES_PER_APPROACH = 2;
  localparam int unsigned NUM_LANES          = NUM_APPROACHES * LANES_PER_APPROACH;

  localparam int unsigned DEF_YELLOW_TIME = 3;
  localparam int unsigned DEF_ALLRED_TIME = 2;
  localparam int unsigned DEF_SERVE_TIME  = 5;
  localparam int unsigned DEF_RESUME_TIME = 5;
  localparam int unsigned DEF_TIMER_W     = 7;

  typedef enum logic [2:0] {
    NORMAL,
    YELLOW,
    ALL_RED,
    SERVE,
    EXIT_YELLOW
  } preemptState_e;

  // Lane mask covering both lanes of one approach.
  function automatic logic [0:NUM_LANES-1] pairMask(input logic [1:0] approach);
    logic [0:NUM_LANES-1] m;
    m = '0;
    m[{approach, 1'b0}] = 1'b1;
    m[{approach, 1'b1}] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational round-robin pick among four pending approaches,
// scanning upward from ptr with wrap-around.
module rr_arbiter4 (
  input  logic [3:0] pending,
  input  logic [1:0] ptr,
  output logic [1:0] winner,
  output logic       valid
);

  logic [1:0] idx;

  always_comb begin
    winner = ptr;
    valid  = 1'b0;
    idx    = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!valid && pending[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/emergency_preempt_ctrl.sv
// Emergency preemption controller: latches lane requests per approach and runs
// yellow -> all-red -> serve sequences before handing back to the normal sequencer.
module emergency_preempt_ctrl
  import emergency_preempt_ctrl_pkg::*;
#(
  parameter int unsigned YELLOW_TIME = DEF_YELLOW_TIME,
  parameter int unsigned ALLRED_TIME = DEF_ALLRED_TIME,
  parameter int unsigned SERVE_TIME  = DEF_SERVE_TIME,
  parameter int unsigned RESUME_TIME = DEF_RESUME_TIME,
  parameter int unsigned TIMER_W     = DEF_TIMER_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [0:7]         emergencyLane,
  input  logic [0:7]         normalGreen,
  output logic [0:7]         laneOutput,
  output logic [0:7]         yellowOutput,
  output logic               loadCommand,
  output logic [TIMER_W-1:0] loadTime,
  output logic               preemptActive,
  output logic [1:0]         grantApproach
);

  preemptState_e        stateQ, stateNext;
  logic [TIMER_W-1:0]   timerQ, timerNext;
  logic [3:0]           pendingQ, pendingNext, approachReq, clr;
  logic [1:0]           rrPtrQ, rrPtrNext;
  logic [1:0]           winnerQ, winnerNext, grantNext;
  logic [1:0]           arbWinner;
  logic                 arbValid;
  logic [0:7]           clearMaskQ, clearMaskNext;
  logic [0:7]           laneNext, yellowNext;
  logic                 loadNext, serveEntry, expire;

  assign loadTime = TIMER_W'(RESUME_TIME);

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      approachReq[k] = |emergencyLane[k*2 +: 2];
    end
  end

  rr_arbiter4 u_arb (
    .pending (pendingQ),
    .ptr     (rrPtrQ),
    .winner  (arbWinner),
    .valid   (arbValid)
  );

  // Next-state, timer, arbitration bookkeeping and registered-output values.
  always_comb begin
    stateNext     = stateQ;
    timerNext     = timerQ;
    clearMaskNext = clearMaskQ;
    winnerNext    = winnerQ;
    grantNext     = grantApproach;
    rrPtrNext     = rrPtrQ;
    clr           = '0;
    serveEntry    = 1'b0;
    laneNext      = '0;
    yellowNext    = '0;
    loadNext      = 1'b0;
    expire        = tick && (timerQ == TIMER_W'(1));

    if (tick && (timerQ != '0)) begin
      timerNext = timerQ - TIMER_W'(1);
    end

    case (stateQ)
      NORMAL: begin
        if (arbValid) begin
          winnerNext = arbWinner;
          if (normalGreen == pairMask(arbWinner)) begin
            serveEntry = 1'b1;
          end else if (normalGreen == '0) begin
            stateNext = ALL_RED;
            timerNext = TIMER_W'(ALLRED_TIME);
          end else begin
            stateNext     = YELLOW;
            timerNext     = TIMER_W'(YELLOW_TIME);
            clearMaskNext = normalGreen;
          end
        end
      end
      YELLOW: begin
        if (expire) begin
          stateNext = ALL_RED;
          timerNext = TIMER_W'(ALLRED_TIME);
        end
      end
      ALL_RED: begin
        if (expire) begin
          serveEntry = 1'b1;
        end
      end
      SERVE: begin
        if (expire) begin
          if (arbValid && (arbWinner == grantApproach)) begin
            winnerNext = arbWinner;
            serveEntry = 1'b1;
          end else begin
            stateNext     = arbValid ? YELLOW : EXIT_YELLOW;
            winnerNext    = arbValid ? arbWinner : winnerQ;
            timerNext     = TIMER_W'(YELLOW_TIME);
            clearMaskNext = pairMask(grantApproach);
          end
        end
      end
      EXIT_YELLOW: begin
        if (expire) begin
          stateNext = NORMAL;
          timerNext = '0;
          loadNext  = 1'b1;
        end
      end
      default: begin
        stateNext = NORMAL;
        timerNext = '0;
      end
    endcase

    if (serveEntry) begin
      stateNext = SERVE;
      timerNext = TIMER_W'(SERVE_TIME);
      grantNext = winnerNext;
      rrPtrNext = winnerNext + 2'd1;
      clr       = 4'b0001 << winnerNext;
    end

    pendingNext = (pendingQ & ~clr) | approachReq;

    case (stateNext)
      NORMAL:              laneNext   = normalGreen;
      YELLOW, EXIT_YELLOW: yellowNext = clearMaskNext;
      SERVE:               laneNext   = pairMask(grantNext);
      default: begin
        laneNext   = '0;
        yellowNext = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ        <= NORMAL;
      timerQ        <= '0;
      pendingQ      <= '0;
      rrPtrQ        <= '0;
      winnerQ       <= '0;
      clearMaskQ    <= '0;
      laneOutput    <= '0;
      yellowOutput  <= '0;
      loadCommand   <= 1'b0;
      preemptActive <= 1'b0;
      grantApproach <= '0;
    end else begin
      stateQ        <= stateNext;
      timerQ        <= timerNext;
      pendingQ      <= pendingNext;
      rrPtrQ        <= rrPtrNext;
      winnerQ       <= winnerNext;
      clearMaskQ    <= clearMaskNext;
      laneOutput    <= laneNext;
      yellowOutput  <= yellowNext;
      loadCommand   <= loadNext;
      preemptActive <= (stateNext != NORMAL);
      grantApproach <= grantNext;
    end
  end

endmodule

// File: tb/tb_emergency_preempt_ctrl.sv
// Directed and random-stress bench for emergency_preempt_ctrl.
module tb_emergency_preempt_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [0:7] emergencyLane;
  logic [0:7] normalGreen;
  logic [0:7] laneOutput;
  logic [0:7] yellowOutput;
  logic       loadCommand;
  logic [6:0] loadTime;
  logic       preemptActive;
  logic [1:0] grantApproach;

  int checkCount = 0;
  int errorCount = 0;

  logic [0:7] pairTbl [4] = '{8'b1100_0000, 8'b0011_0000, 8'b0000_1100, 8'b0000_0011};

  emergency_preempt_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .emergencyLane (emergencyLane),
    .normalGreen   (normalGreen),
    .laneOutput    (laneOutput),
    .yellowOutput  (yellowOutput),
    .loadCommand   (loadCommand),
    .loadTime      (loadTime),
    .preemptActive (preemptActive),
    .grantApproach (grantApproach)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    tick = 1'b1;
    emergencyLane = '0;
    normalGreen = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Steps n cycles inside a preemption, checking the masks each cycle.
  task automatic phase(input string tag, input logic [0:7] lane, input logic [0:7] yel,
                       input int n, input logic chkGrant, input logic [1:0] grant);
    for (int i = 0; i < n; i++) begin
      step();
      checkEq({tag, " lane"}, 32'(laneOutput), 32'(lane));
      checkEq({tag, " yellow"}, 32'(yellowOutput), 32'(yel));
      checkEq({tag, " load"}, 32'(loadCommand), 32'd0);
      checkEq({tag, " active"}, 32'(preemptActive), 32'd1);
      if (chkGrant) checkEq({tag, " grant"}, 32'(grantApproach), 32'(grant));
    end
  endtask

  logic [1:0] seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic       found;
  logic [0:7] prevLane;
  logic       prevActive;
  logic [0:7] clrMask;

  initial begin
    // Reset state
    applyReset();
    checkEq("rst lane", 32'(laneOutput), 32'd0);
    checkEq("rst yellow", 32'(yellowOutput), 32'd0);
    checkEq("rst load", 32'(loadCommand), 32'd0);
    checkEq("rst active", 32'(preemptActive), 32'd0);
    checkEq("rst grant", 32'(grantApproach), 32'd0);
    checkEq("loadTime", 32'(loadTime), 32'd5);

    // Single-cycle request on lane 5 while approach 0 is green
    normalGreen = 8'b1100_0000;
    step();
    emergencyLane = 8'b0000_0100;
    step();
    emergencyLane = '0;
    checkEq("t2 normal lane", 32'(laneOutput), 32'(8'b1100_0000));
    checkEq("t2 normal active", 32'(preemptActive), 32'd0);
    phase("t2 yellow", 8'b0000_0000, 8'b1100_0000, 3, 1'b0, 2'd0);
    phase("t2 allred", 8'b0000_0000, 8'b0000_0000, 2, 1'b0, 2'd0);
    phase("t2 serve", 8'b0000_1100, 8'b0000_0000, 5, 1'b1, 2'd2);
    phase("t2 exit", 8'b0000_0000, 8'b0000_1100, 3, 1'b0, 2'd0);
    step();
    checkEq("t2 load pulse", 32'(loadCommand), 32'd1);
    checkEq("t2 loadTime", 32'(loadTime), 32'd5);
    checkEq("t2 back lane", 32'(laneOutput), 32'(8'b1100_0000));
    checkEq("t2 back active", 32'(preemptActive), 32'd0);
    step();
    checkEq("t2 load once", 32'(loadCommand), 32'd0);

    // Request for the currently green approach: direct serve, repeats while held
    applyReset();
    normalGreen = 8'b0011_0000;
    step();
    emergencyLane = 8'b0010_0000;
    step();
    checkEq("t3 pre active", 32'(preemptActive), 32'd0);
    step();
    checkEq("t3 direct active", 32'(preemptActive), 32'd1);
    checkEq("t3 direct grant", 32'(grantApproach), 32'd1);
    checkEq("t3 direct lane", 32'(laneOutput), 32'(8'b0011_0000));
    checkEq("t3 direct yellow", 32'(yellowOutput), 32'd0);
    phase("t3 held", 8'b0011_0000, 8'b0000_0000, 10, 1'b1, 2'd1);
    emergencyLane = '0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (yellowOutput != '0) found = 1'b1;
    end
    checkEq("t3 exit seen", 32'(found), 32'd1);
    checkEq("t3 exit yellow", 32'(yellowOutput), 32'(8'b0011_0000));
    checkEq("t3 exit lane", 32'(laneOutput), 32'd0);
    phase("t3 exit", 8'b0000_0000, 8'b0011_0000, 2, 1'b0, 2'd0);
    step();
    checkEq("t3 load pulse", 32'(loadCommand), 32'd1);

    // All approaches requesting: strict round-robin, no return to normal
    applyReset();
    normalGreen = 8'b0000_0011;
    step();
    emergencyLane = 8'hFF;
    step();
    for (int k = 0; k < 5; k++) begin
      clrMask = (k == 0) ? 8'b0000_0011 : pairTbl[seq[k-1]];
      phase("t4 yellow", 8'b0000_0000, clrMask, 3, 1'b0, 2'd0);
      phase("t4 allred", 8'b0000_0000, 8'b0000_0000, 2, 1'b0, 2'd0);
      phase("t4 serve", pairTbl[seq[k]], 8'b0000_0000, 5, 1'b1, seq[k]);
    end

    // Approach 3 arriving during all-red of an approach 1 preemption
    applyReset();
    normalGreen = 8'b1100_0000;
    step();
    emergencyLane = 8'b0010_0000;
    step();
    emergencyLane = '0;
    phase("t5 yellow", 8'b0000_0000, 8'b1100_0000, 3, 1'b0, 2'd0);
    phase("t5 allred", 8'b0000_0000, 8'b0000_0000, 1, 1'b0, 2'd0);
    emergencyLane = 8'b0000_0001;
    phase("t5 allred", 8'b0000_0000, 8'b0000_0000, 1, 1'b0, 2'd0);
    emergencyLane = '0;
    phase("t5 serve1", 8'b0011_0000, 8'b0000_0000, 5, 1'b1, 2'd1);
    phase("t5 yellow1", 8'b0000_0000, 8'b0011_0000, 3, 1'b0, 2'd0);
    phase("t5 allred1", 8'b0000_0000, 8'b0000_0000, 2, 1'b0, 2'd0);
    phase("t5 serve3", 8'b0000_0011, 8'b0000_0000, 5, 1'b1, 2'd3);
    phase("t5 exit", 8'b0000_0000, 8'b0000_0011, 3, 1'b0, 2'd0);
    step();
    checkEq("t5 load pulse", 32'(loadCommand), 32'd1);

    // Asynchronous reset while approach 2 is being served
    applyReset();
    step();
    emergencyLane = 8'b0000_1000;
    step();
    emergencyLane = '0;
    phase("t1 allred", 8'b0000_0000, 8'b0000_0000, 2, 1'b0, 2'd0);
    phase("t1 serve", 8'b0000_1100, 8'b0000_0000, 1, 1'b1, 2'd2);
    emergencyLane = 8'b1000_0000;
    step();
    emergencyLane = '0;
    #2 rst = 1'b1;
    #1;
    checkEq("t1 rst lane", 32'(laneOutput), 32'd0);
    checkEq("t1 rst yellow", 32'(yellowOutput), 32'd0);
    checkEq("t1 rst active", 32'(preemptActive), 32'd0);
    checkEq("t1 rst grant", 32'(grantApproach), 32'd0);
    checkEq("t1 rst load", 32'(loadCommand), 32'd0);
    step();
    rst = 1'b0;
    step();
    step();
    step();
    checkEq("t1 pending cleared", 32'(preemptActive), 32'd0);
    checkEq("t1 post lane", 32'(laneOutput), 32'd0);

    // Random tick/request stress on the safety invariants
    applyReset();
    prevLane = '0;
    prevActive = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick = 1'($urandom_range(0, 1));
      emergencyLane = ($urandom_range(0, 11) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 15) == 0) normalGreen = pairTbl[$urandom_range(0, 3)];
      step();
      checkEq("stress overlap", 32'(laneOutput & yellowOutput), 32'd0);
      checkEq("stress direct switch",
              32'(prevActive && preemptActive && (prevLane != '0) && (laneOutput != '0)
                  && (laneOutput != prevLane)), 32'd0);
      prevLane = laneOutput;
      prevActive = preemptActive;
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
